// File: rtl/pwm_tone_mixer.sv
// NUM_CH sine tone oscillators mixed into one 8-bit PWM audio output.
// Define PWM_VOLUME_EN to add per-channel attenuation via cfg_vol.
module pwm_tone_mixer #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 12,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
`ifdef PWM_VOLUME_EN
    input  logic [2:0]       cfg_vol,
`endif
    output logic             pwm,
    output logic             frame
);

    localparam int SHIFT = $clog2(NUM_CH);
    localparam int SUM_W = 8 + SHIFT;

    logic [DIV_W-1:0] div_q   [NUM_CH];
    logic [DIV_W-1:0] div_d   [NUM_CH];
    logic [DIV_W-1:0] cnt_q   [NUM_CH];
    logic [DIV_W-1:0] cnt_d   [NUM_CH];
    logic [5:0]       phase_q [NUM_CH];
    logic [5:0]       phase_d [NUM_CH];
`ifdef PWM_VOLUME_EN
    logic [2:0]       vol_q   [NUM_CH];
    logic [2:0]       vol_d   [NUM_CH];
`endif

    logic [7:0] mix_q, mix_d;
    logic [7:0] duty_q, duty_d;
    logic [7:0] pwm_cnt_q, pwm_cnt_d;
    logic       pwm_q, pwm_d;
    logic       frame_q, frame_d;

    logic [3:0]              idx;
    logic signed [7:0]       mag;
    logic signed [7:0]       smp;
    logic signed [SUM_W-1:0] smp_ext;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] scaled;
    logic [7:0]              scaled_lo;

    // Quarter-wave table sampled at odd multiples of pi/64, so no zero crossing sample.
    function automatic logic [6:0] sine_mag(input logic [3:0] i);
        case (i)
            4'd0:    return 7'd6;
            4'd1:    return 7'd19;
            4'd2:    return 7'd31;
            4'd3:    return 7'd43;
            4'd4:    return 7'd54;
            4'd5:    return 7'd65;
            4'd6:    return 7'd76;
            4'd7:    return 7'd85;
            4'd8:    return 7'd94;
            4'd9:    return 7'd102;
            4'd10:   return 7'd109;
            4'd11:   return 7'd115;
            4'd12:   return 7'd120;
            4'd13:   return 7'd123;
            4'd14:   return 7'd126;
            default: return 7'd127;
        endcase
    endfunction

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            div_d[c]   = div_q[c];
            cnt_d[c]   = cnt_q[c];
            phase_d[c] = phase_q[c];
`ifdef PWM_VOLUME_EN
            vol_d[c]   = vol_q[c];
`endif
            if (div_q[c] != '0) begin
                if (cnt_q[c] == div_q[c]) begin
                    cnt_d[c]   = '0;
                    phase_d[c] = phase_q[c] + 6'd1;
                end else begin
                    cnt_d[c] = cnt_q[c] + 1'b1;
                end
            end
            // A write restarts the divider but leaves the phase alone to avoid clicks.
            if (cfg_we && (cfg_ch == CH_W'(c))) begin
                div_d[c] = cfg_div;
                cnt_d[c] = '0;
`ifdef PWM_VOLUME_EN
                vol_d[c] = cfg_vol;
`endif
            end
        end
    end

    always_comb begin
        idx     = '0;
        mag     = '0;
        smp     = '0;
        smp_ext = '0;
        sum     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            idx = phase_q[c][4] ? ~phase_q[c][3:0] : phase_q[c][3:0];
            mag = $signed({1'b0, sine_mag(idx)});
            smp = phase_q[c][5] ? -mag : mag;
            if (div_q[c] == '0) begin
                smp = '0;
            end
`ifdef PWM_VOLUME_EN
            smp = smp >>> vol_q[c];
`endif
            smp_ext = smp;
            sum     = sum + smp_ext;
        end
        scaled    = sum >>> SHIFT;
        scaled_lo = scaled[7:0];
        mix_d     = scaled_lo + 8'd128;
    end

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        frame_d   = (pwm_cnt_q == 8'hFF);
        duty_d    = frame_d ? mix_q : duty_q;
        pwm_d     = (pwm_cnt_q < duty_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                div_q[c]   <= '0;
                cnt_q[c]   <= '0;
                phase_q[c] <= '0;
`ifdef PWM_VOLUME_EN
                vol_q[c]   <= '0;
`endif
            end
            mix_q     <= 8'd128;
            duty_q    <= 8'd128;
            pwm_cnt_q <= '0;
            pwm_q     <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                div_q[c]   <= div_d[c];
                cnt_q[c]   <= cnt_d[c];
                phase_q[c] <= phase_d[c];
`ifdef PWM_VOLUME_EN
                vol_q[c]   <= vol_d[c];
`endif
            end
            mix_q     <= mix_d;
            duty_q    <= duty_d;
            pwm_cnt_q <= pwm_cnt_d;
            pwm_q     <= pwm_d;
            frame_q   <= frame_d;
        end
    end

    assign pwm   = pwm_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_pwm_tone_mixer.sv
// Randomized bench for pwm_tone_mixer; the model derives each channel's phase
// from the time of its last write and the sine directly from $sin.
module tb_pwm_tone_mixer;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 12;
    localparam int CH_W   = 2;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             cfg_we  = 1'b0;
    logic [CH_W-1:0]  cfg_ch  = '0;
    logic [DIV_W-1:0] cfg_div = '0;
`ifdef PWM_VOLUME_EN
    logic [2:0]       cfg_vol = '0;
`endif
    logic             pwm;
    logic             frame;

    int num_checks = 0;
    int num_errors = 0;

    // Model: a channel's configuration since its last write at edge w_edge.
    int w_edge [NUM_CH];
    int p0     [NUM_CH];
    int m_div  [NUM_CH];
    int m_vol  [NUM_CH];
    int t;
    int mix_prev;
    int duty_prev;

    pwm_tone_mixer #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
`ifdef PWM_VOLUME_EN
        .cfg_vol (cfg_vol),
`endif
        .pwm     (pwm),
        .frame   (frame)
    );

    always #5 clk = ~clk;

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int sine_of(input int p);
        real x;
        x = 127.0 * $sin(3.14159265358979 * real'(2 * p + 1) / 64.0);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    function automatic int phase_at(input int c, input int at);
        if (m_div[c] == 0) return p0[c];
        return (p0[c] + (at - w_edge[c]) / (m_div[c] + 1)) % 64;
    endfunction

    function automatic int sample_of(input int c, input int at);
        if (m_div[c] == 0) return 0;
        return floor_div(sine_of(phase_at(c, at)), 1 << m_vol[c]);
    endfunction

    task automatic modelReset();
        for (int c = 0; c < NUM_CH; c++) begin
            w_edge[c] = 0;
            p0[c]     = 0;
            m_div[c]  = 0;
            m_vol[c]  = 0;
        end
        t         = 0;
        mix_prev  = 128;
        duty_prev = 128;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, observed, expected, t);
        end
    endtask

    // One clock edge; called at a falling edge, checks outputs at the next falling edge.
    task automatic applyStimulus(input bit we, input int ch, input int dv, input int vl, input bit rst);
        int sum, mix_new, duty_new, t_next;
        bit pwm_exp, frame_exp;
        if (rst) begin
            rst_n  = 1'b0;
            cfg_we = 1'b0;
            @(negedge clk);
            modelReset();
            checkOutput("rst_pwm", {31'd0, pwm}, 32'd0);
            checkOutput("rst_frame", {31'd0, frame}, 32'd0);
            rst_n = 1'b1;
            return;
        end
        t_next = t + 1;
        sum = 0;
        for (int c = 0; c < NUM_CH; c++) sum += sample_of(c, t);
        mix_new   = 128 + floor_div(sum, NUM_CH);
        pwm_exp   = ((t % 256) < duty_prev);
        frame_exp = ((t_next % 256) == 0);
        duty_new  = frame_exp ? mix_prev : duty_prev;
        if (we) begin
            p0[ch]     = phase_at(ch, t_next);
            w_edge[ch] = t_next;
            m_div[ch]  = dv;
`ifdef PWM_VOLUME_EN
            m_vol[ch]  = vl;
            cfg_vol    = 3'(vl);
`endif
        end
        cfg_we  = we;
        cfg_ch  = CH_W'(ch);
        cfg_div = DIV_W'(dv);
        @(negedge clk);
        t         = t_next;
        mix_prev  = mix_new;
        duty_prev = duty_new;
        checkOutput("pwm", {31'd0, pwm}, {31'd0, pwm_exp});
        checkOutput("frame", {31'd0, frame}, {31'd0, frame_exp});
        cfg_we = 1'b0;
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        int r, ch, dv, vl;
        modelReset();
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        runIdle(600);

        applyStimulus(1'b1, 0, 9, 3, 1'b0);
        runIdle(800);
        applyStimulus(1'b1, 0, 0, 3, 1'b0);
        runIdle(300);

        applyStimulus(1'b1, 1, 3, 1, 1'b0);
        applyStimulus(1'b1, 2, 7, 0, 1'b0);
        runIdle(137);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        runIdle(520);

        for (int i = 0; i < 12000; i++) begin
            r = $urandom_range(0, 99);
            if (r == 0 && $urandom_range(0, 39) == 0) begin
                applyStimulus(1'b0, 0, 0, 0, 1'b1);
            end else if (r < 4) begin
                ch = $urandom_range(0, NUM_CH - 1);
                case ($urandom_range(0, 9))
                    0:       dv = 0;
                    8:       dv = $urandom_range(16, 63);
                    9:       dv = $urandom_range(0, 4095);
                    default: dv = $urandom_range(1, 15);
                endcase
                vl = $urandom_range(0, 7);
                applyStimulus(1'b1, ch, dv, vl, 1'b0);
            end else begin
                applyStimulus(1'b0, 0, 0, 0, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
